// File: rtl/cios_sequencer_if.sv
`timescale 1ns/1ps
// Control bundle between the CIOS sequencer and the block that launches it.
// The sequencer consumes start/stall and drives status, indices and cell strobes.
interface cios_sequencer_if #(
  parameter int IDX_W = 4
);
  logic             start;
  logic             stall;
  logic             busy;
  logic             done;
  logic [IDX_W-1:0] i_idx;
  logic [IDX_W-1:0] j_idx;
  logic             mul_en;
  logic             alpha_en;
  logic             m_en;
  logic             red_en;
  logic             sub_en;
  logic             last_j;

  modport master (
    output start, stall,
    input  busy, done, i_idx, j_idx,
    input  mul_en, alpha_en, m_en, red_en, sub_en, last_j
  );

  modport slave (
    input  start, stall,
    output busy, done, i_idx, j_idx,
    output mul_en, alpha_en, m_en, red_en, sub_en, last_j
  );
endinterface

// File: rtl/cios_sequencer.sv
`timescale 1ns/1ps
// Word-serial CIOS Montgomery control sequencer: steps i/j through multiply, fold,
// m-computation, reduction and final subtract, with drain gaps (CELL_LAT >= 1).
module cios_sequencer #(
  parameter int S        = 8,
  parameter int CELL_LAT = 2,
  parameter int M_LAT    = 2,
  parameter int IDX_W    = $clog2(S + 1)
) (
  input logic             clk,
  input logic             rst,
  cios_sequencer_if.slave bus
);

  localparam int CNT_MAX = (CELL_LAT > M_LAT) ? CELL_LAT : M_LAT;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

  localparam logic [IDX_W-1:0] J_LAST = IDX_W'(S - 1);
  localparam logic [IDX_W-1:0] J_FOLD = IDX_W'(S);
  localparam logic [CNT_W-1:0] DRAIN_END = CNT_W'(CELL_LAT - 1);
  localparam logic [CNT_W-1:0] MLAT_END  = CNT_W'(M_LAT);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_MUL,
    ST_MFOLD,
    ST_DRAIN_A,
    ST_MCOMP,
    ST_RED,
    ST_RFOLD,
    ST_DRAIN_B,
    ST_FSUB,
    ST_FDRAIN,
    ST_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] i_q, i_d;
  logic [IDX_W-1:0] j_q, j_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic busy_q, done_q;
  logic mul_q, alpha_q, m_q, red_q, sub_q, last_q;

  logic mul_d, alpha_d, m_d, red_d, sub_d, last_d, busy_d, done_d;

  // NOTE: every always_comb target gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    cnt_d   = cnt_q;
    if (!bus.stall) begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_d = ST_MUL;
            i_d     = '0;
            j_d     = '0;
            cnt_d   = '0;
          end
        end
        ST_MUL: begin
          if (j_q == J_LAST) begin
            state_d = ST_MFOLD;
            j_d     = J_FOLD;
          end else begin
            j_d = j_q + IDX_W'(1);
          end
        end
        ST_MFOLD: begin
          state_d = ST_DRAIN_A;
          j_d     = '0;
          cnt_d   = '0;
        end
        ST_DRAIN_A: begin
          if (cnt_q == DRAIN_END) begin
            state_d = ST_MCOMP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_MCOMP: begin
          // cnt 0 is the m_en issue; cnt 1..M_LAT wait for the m-unit result.
          if (cnt_q == MLAT_END) begin
            state_d = ST_RED;
            j_d     = '0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RED: begin
          if (j_q == J_LAST) begin
            state_d = ST_RFOLD;
            j_d     = J_FOLD;
          end else begin
            j_d = j_q + IDX_W'(1);
          end
        end
        ST_RFOLD: begin
          state_d = ST_DRAIN_B;
          j_d     = '0;
          cnt_d   = '0;
        end
        ST_DRAIN_B: begin
          if (cnt_q == DRAIN_END) begin
            cnt_d = '0;
            j_d   = '0;
            if (i_q == J_LAST) begin
              state_d = ST_FSUB;
            end else begin
              state_d = ST_MUL;
              i_d     = i_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_FSUB: begin
          if (j_q == J_FOLD) begin
            state_d = ST_FDRAIN;
            j_d     = '0;
            cnt_d   = '0;
          end else begin
            j_d = j_q + IDX_W'(1);
          end
        end
        ST_FDRAIN: begin
          if (cnt_q == DRAIN_END) begin
            state_d = ST_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Strobes are decoded from the next state so the registered copy lines up with it.
  always_comb begin
    mul_d   = (state_d == ST_MUL);
    alpha_d = (state_d == ST_MFOLD) || (state_d == ST_RFOLD);
    m_d     = (state_d == ST_MCOMP) && (cnt_d == '0);
    red_d   = (state_d == ST_RED);
    sub_d   = (state_d == ST_FSUB);
    last_d  = ((mul_d || red_d) && (j_d == J_LAST)) || alpha_d ||
              (sub_d && (j_d == J_FOLD));
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  // NOTE: asynchronous reset clears state and outputs at once; all state uses non-blocking <=.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mul_q   <= 1'b0;
      alpha_q <= 1'b0;
      m_q     <= 1'b0;
      red_q   <= 1'b0;
      sub_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mul_q   <= mul_d;
      alpha_q <= alpha_d;
      m_q     <= m_d;
      red_q   <= red_d;
      sub_q   <= sub_d;
      last_q  <= last_d;
    end
  end

  // NOTE: stall must silence the issue in the very cycle it is raised, so the
  // registered strobes are masked combinationally; the held registers replay it later.
  assign bus.mul_en   = mul_q   & ~bus.stall;
  assign bus.alpha_en = alpha_q & ~bus.stall;
  assign bus.m_en     = m_q     & ~bus.stall;
  assign bus.red_en   = red_q   & ~bus.stall;
  assign bus.sub_en   = sub_q   & ~bus.stall;
  assign bus.last_j   = last_q  & ~bus.stall;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.i_idx    = i_q;
  assign bus.j_idx    = j_q;

endmodule

// File: tb/tb_cios_sequencer.sv
`timescale 1ns/1ps
// Scoreboard bench for cios_sequencer at S=4, CELL_LAT=2, M_LAT=2 (P = 17 cycles).
// Directed scenarios push hand-timed strobe events; a negedge monitor pops and compares.
module tb_cios_sequencer;

  localparam int IDX_W = 3;
  localparam int NEVER = 1 << 30;

  localparam logic [5:0] K_MUL   = 6'b000001;
  localparam logic [5:0] K_ALPHA = 6'b000010;
  localparam logic [5:0] K_M     = 6'b000100;
  localparam logic [5:0] K_RED   = 6'b001000;
  localparam logic [5:0] K_SUB   = 6'b010000;
  localparam logic [5:0] K_DONE  = 6'b100000;

  typedef struct {
    int         cyc;
    logic [5:0] kind;
    int         i;
    int         j;
    logic       last;
    logic       chk_i;
    logic       chk_j;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  sb[$];

  int m_stall_at  = NEVER;
  int m_stall_len = 0;
  int m_cutoff    = NEVER;

  cios_sequencer_if #(.IDX_W(IDX_W)) bus ();

  cios_sequencer #(
    .S       (4),
    .CELL_LAT(2),
    .M_LAT   (2),
    .IDX_W   (IDX_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic add_ev(input int c, input logic [5:0] k, input int i, input int j,
                        input logic last, input logic ci, input logic cj);
    ev_t e;
    if (c >= m_stall_at) c += m_stall_len;
    if (c < m_cutoff) begin
      e = '{c, k, i, j, last, ci, cj};
      sb.push_back(e);
    end
  endtask

  // Hand-derived timetable of one S=4 run whose start is sampled in cycle t0.
  task automatic push_run(input int t0, input int stall_at, input int stall_len, input int cutoff);
    int b;
    m_stall_at  = stall_at;
    m_stall_len = stall_len;
    m_cutoff    = cutoff;
    for (int i = 0; i < 4; i++) begin
      b = t0 + 1 + 17 * i;
      for (int j = 0; j < 4; j++) add_ev(b + j, K_MUL, i, j, j == 3, 1'b1, 1'b1);
      add_ev(b + 4, K_ALPHA, i, 4, 1'b1, 1'b1, 1'b1);
      add_ev(b + 7, K_M, i, 0, 1'b0, 1'b1, 1'b0);
      for (int j = 0; j < 4; j++) add_ev(b + 10 + j, K_RED, i, j, j == 3, 1'b1, 1'b1);
      add_ev(b + 14, K_ALPHA, i, 4, 1'b1, 1'b1, 1'b1);
    end
    for (int j = 0; j <= 4; j++) add_ev(t0 + 69 + j, K_SUB, 0, j, j == 4, 1'b0, 1'b1);
    add_ev(t0 + 76, K_DONE, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: every visible strobe or done must match the oldest expected event.
  always @(negedge clk) begin
    logic [5:0] kind;
    ev_t        e;
    kind = {bus.done, bus.sub_en, bus.red_en, bus.m_en, bus.alpha_en, bus.mul_en};
    if (|kind) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event at cycle %0d: kind %b, none expected", cyc, kind);
      end else begin
        e = sb.pop_front();
        if (cyc != e.cyc || kind !== e.kind || bus.last_j !== e.last ||
            (e.chk_i && int'(bus.i_idx) != e.i) || (e.chk_j && int'(bus.j_idx) != e.j)) begin
          errors++;
          $display("FAIL event at cycle %0d: kind %b i %0d j %0d last %b; expected cycle %0d kind %b i %0d j %0d last %b",
                   cyc, kind, bus.i_idx, bus.j_idx, bus.last_j, e.cyc, e.kind, e.i, e.j, e.last);
        end
      end
    end
  end

  task automatic goto(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic check_drained(input string name);
    check(name, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    bus.start = 1'b0;
    bus.stall = 1'b0;

    // Reset asserted mid-cycle forces every output low at once.
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("reset_outputs",
             {bus.busy, bus.done, bus.mul_en, bus.alpha_en, bus.m_en, bus.red_en,
              bus.sub_en, bus.last_j, bus.i_idx, bus.j_idx}, 0);
    goto(cyc + 3);
    rst = 1'b0;
    goto(cyc + 20);
    check("idle_busy", bus.busy, 0);
    check("idle_idx", {bus.i_idx, bus.j_idx}, 0);

    // Nominal run.
    t0 = cyc + 2;
    goto(t0);
    push_run(t0, NEVER, 0, NEVER);
    check("nom_busy_c0", bus.busy, 0);
    pulse_start();
    check("nom_busy_c1", bus.busy, 1);
    check("nom_i_c1", bus.i_idx, 0);
    goto(t0 + 18);
    check("nom_i_iter2", bus.i_idx, 1);
    goto(t0 + 76);
    check("nom_busy_done", bus.busy, 1);
    goto(t0 + 77);
    check("nom_busy_fall", {bus.busy, bus.done}, 0);
    goto(t0 + 80);
    check_drained("nom_drained");

    // Stall across cycles 3..5.
    t0 = cyc + 2;
    goto(t0);
    push_run(t0, t0 + 3, 3, NEVER);
    pulse_start();
    goto(t0 + 2);
    @(posedge clk);
    #1 bus.stall = 1'b1;
    goto(t0 + 4);
    check("stall_j_hold", bus.j_idx, 2);
    check("stall_busy_hold", bus.busy, 1);
    goto(t0 + 5);
    @(posedge clk);
    #1 bus.stall = 1'b0;
    goto(t0 + 80);
    check("stall_busy_fall", bus.busy, 0);
    check_drained("stall_drained");

    // Start pulsed while busy is ignored.
    t0 = cyc + 2;
    goto(t0);
    push_run(t0, NEVER, 0, NEVER);
    pulse_start();
    goto(t0 + 10);
    pulse_start();
    goto(t0 + 80);
    check_drained("busy_start_drained");

    // Abort by reset in cycle 40, relaunch in cycle 45.
    t0 = cyc + 2;
    goto(t0);
    push_run(t0, NEVER, 0, t0 + 40);
    push_run(t0 + 45, NEVER, 0, NEVER);
    pulse_start();
    goto(t0 + 39);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("abort_outputs",
             {bus.busy, bus.done, bus.mul_en, bus.alpha_en, bus.m_en, bus.red_en,
              bus.sub_en, bus.last_j, bus.i_idx, bus.j_idx}, 0);
    goto(t0 + 42);
    rst = 1'b0;
    goto(t0 + 45);
    pulse_start();
    goto(t0 + 46);
    check("abort_relaunch_busy", bus.busy, 1);
    goto(t0 + 125);
    check_drained("abort_drained");

    // Start held high: runs launch back to back from IDLE.
    t0 = cyc + 2;
    goto(t0);
    push_run(t0, NEVER, 0, NEVER);
    push_run(t0 + 77, NEVER, 0, NEVER);
    bus.start = 1'b1;
    goto(t0 + 77);
    check("b2b_idle_gap", bus.busy, 0);
    goto(t0 + 153);
    bus.start = 1'b0;
    goto(t0 + 160);
    check("b2b_final_busy", bus.busy, 0);
    check_drained("b2b_drained");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cios_sequencer.md
# cios_sequencer

Control sequencer for the word-serial CIOS Montgomery multiplier. It steps the outer word index i and inner word index j through the multiply, carry-fold, m-computation, reduction and final-subtract phases. It drives the enable strobes and word indices for the pipelined datapath cells (adder/carry cells, multiply cells, m-unit). Pipeline drain gaps are inserted so that no phase consumes a result before the producing cell has written it.

## Interface
- S, default 8: number of WIDTH-bit words per operand (S ≥ 2)
- CELL_LAT, default 2: latency in cycles from an issue strobe to a valid (Sout, Cout) of a datapath cell
- M_LAT, default 2: latency of the m-computation unit
- IDX_W, default $clog2(S+1): width of the index outputs

- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin one modular multiplication; sampled only in IDLE
- stall  in  1  freeze sequencer; counters and state hold, all strobes forced low
- busy  out  1  high from the first issue cycle through the done cycle
- done  out  1  one-cycle pulse after the final-subtract results are drained
- i_idx  out  IDX_W  outer word index, 0..S-1
- j_idx  out  IDX_W  inner word index for the current issue, 0..S
- mul_en  out  1  issue a[j]*b[i] + t[j] + C
- alpha_en  out  1  issue the carry fold t[S] + C (the adder cell)
- m_en  out  1  issue m = t[0]*n' mod 2^WIDTH
- red_en  out  1  issue m*n[j] + t[j] + C
- sub_en  out  1  issue the final conditional-subtract word j
- last_j  out  1  high with any strobe whose j_idx is the last word of its phase

## Operation
- All outputs are registered. Strobes are decoded from the next-state and counter values and registered, so each strobe is valid in the same cycle as its state.
- States:
  - IDLE
  - MUL: j = 0..S-1, mul_en
  - MFOLD: one cycle, alpha_en, j_idx = S
  - DRAIN_A: CELL_LAT cycles, no strobe
  - MCOMP: one cycle, m_en, then M_LAT idle cycles
  - RED: j = 0..S-1, red_en
  - RFOLD: one cycle, alpha_en, j_idx = S
  - DRAIN_B: CELL_LAT cycles
  - FSUB: j = 0..S, sub_en
  - FDRAIN: CELL_LAT cycles
  - DONE: done = 1
- Transitions:
  - IDLE→MUL on start.
  - DRAIN_B→MUL with i+1 when i < S-1; DRAIN_B→FSUB when i = S-1.
  - DONE→IDLE unconditionally.
- j resets to 0 on every phase entry. i resets to 0 on start and increments only on DRAIN_B exit.
- last_j is high with mul_en/red_en at j = S-1, with alpha_en (j = S) and with sub_en at j = S.
- stall:
  - Holds state, i, j and drain/latency counters.
  - All strobes are low while stall is high; busy, i_idx and j_idx hold their values.
  - A stall in DONE holds done high; done is released by the cycle after stall falls.
- start while busy is ignored. start held high across DONE re-launches directly from IDLE on the following edge.

## Timing
- Reset values: busy = done = all strobes = last_j = 0, i_idx = j_idx = 0, state IDLE. rst mid-operation aborts immediately to these values; there is no partial completion and no done pulse.
- Cycle 0 is the cycle in which start is sampled high in IDLE. Cycle 1 is the first MUL issue, and busy is high from cycle 1.
- Per outer iteration: P = 2S + 3 + 2·CELL_LAT + M_LAT cycles.
- Final subtract: S+1 issue cycles plus CELL_LAT drain cycles.
- done rises in cycle S·P + S + 1 + CELL_LAT + 1, with no stall. busy falls in the cycle after done.
- Minimum spacing between a strobe producing t[j] and any strobe consuming it is ≥ CELL_LAT cycles. The drain states guarantee this.

## Test plan
- Reset and idle:
  - Stimulus: assert rst mid-cycle with start low.
  - Response: all outputs 0 asynchronously; no strobe for 20 cycles.
- Nominal run, S=4, CELL_LAT=2, M_LAT=2 (P = 17):
  - Strobes: mul_en in cycles 1–4 (j 0..3), alpha_en in cycle 5 (j = 4), m_en in cycle 8, red_en in cycles 11–14, alpha_en in cycle 15.
  - Second iteration: mul_en resumes in cycle 18 with i_idx = 1.
  - sub_en in cycles 69–73, done in cycle 76, busy low in cycle 77.
- Stall:
  - Stimulus: same run with stall high for cycles 3–5.
  - Response: no strobes in cycles 3–5; mul_en j = 2 appears in cycle 6; done moves to cycle 79.
- Busy start:
  - Stimulus: pulse start in cycle 10 of a run.
  - Response: no effect; done still in cycle 76.
- Abort:
  - Stimulus: assert rst in cycle 40, then start in cycle 45.
  - Response: outputs zero from cycle 40; the new run shows mul_en i = 0, j = 0 in cycle 46 and done in cycle 121.
- Back-to-back:
  - Stimulus: start held high continuously.
  - Response: second run's first mul_en lands 2 cycles after the first run's done; exactly one done per run.
